// File: rtl/tdm_pkg.sv
// Constants and state encoding shared by the receive and transmit ends of the 8-channel TDM link.
package tdm_pkg;
  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;
endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-NCH slot counter: clear has priority over load-to-1, which has priority over increment.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            ld1_i,
  input  logic            en_i,
  output logic [SELW-1:0] cnt_o,
  output logic            wrap_o
);
  logic [SELW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (ld1_i) cnt_d = SELW'(1);
    else if (en_i)  cnt_d = (cnt_q == SELW'(NCH-1)) ? '0 : cnt_q + SELW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == SELW'(NCH-1));
endmodule

// File: rtl/tdm_demux_8ch.sv
// TDM receive demultiplexer: aligns on slot-0 fsync, collects slots in a shadow
// register and publishes each complete frame as one registered word.
module tdm_demux_8ch
  import tdm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in,
  input  logic            in_valid,
  input  logic            fsync,
  output logic [NCH-1:0]  out,
  output logic            out_valid,
  output logic [SELW-1:0] sel,
  output logic            locked,
  output logic            sync_err
);
  state_e         state_q, state_d;
  logic [NCH-1:0] shadow_q, shadow_d;
  logic [NCH-1:0] out_q, out_d;
  logic           ov_q, ov_d;
  logic           se_q, se_d;
  logic           locked_q;
  logic           cnt_clr, cnt_ld1, cnt_en, cnt_wrap;
  logic [SELW-1:0] sel_w;

  tdm_slot_counter u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .ld1_i  (cnt_ld1),
    .en_i   (cnt_en),
    .cnt_o  (sel_w),
    .wrap_o (cnt_wrap)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    ov_d     = 1'b0;
    se_d     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_ld1  = 1'b0;
    cnt_en   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (fsync) begin
            shadow_d[0] = in;
            cnt_ld1     = 1'b1;
            state_d     = LOCK;
          end
        end
        LOCK: begin
          if (sel_w == '0) begin
            if (fsync) begin
              shadow_d[0] = in;
              cnt_ld1     = 1'b1;
            end else begin
              se_d    = 1'b1;
              cnt_clr = 1'b1;
              state_d = HUNT;
            end
          end else if (fsync) begin
            // Early sync restarts the frame; stale shadow bits get overwritten later.
            se_d        = 1'b1;
            shadow_d[0] = in;
            cnt_ld1     = 1'b1;
          end else if (cnt_wrap) begin
            out_d  = {in, shadow_q[NCH-2:0]};
            ov_d   = 1'b1;
            cnt_en = 1'b1;
          end else begin
            shadow_d[sel_w] = in;
            cnt_en          = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      out_q    <= '0;
      ov_q     <= 1'b0;
      se_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      ov_q     <= ov_d;
      se_q     <= se_d;
      locked_q <= (state_d == LOCK);
    end
  end

  assign out       = out_q;
  assign out_valid = ov_q;
  assign sel       = sel_w;
  assign locked    = locked_q;
  assign sync_err  = se_q;
endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Directed plus random stimulus for tdm_demux_8ch, checked every cycle against a
// queue-based frame-assembly model.
module tb_tdm_demux_8ch;
  logic       clk = 1'b0;
  logic       rst, in, in_valid, fsync;
  logic [7:0] out;
  logic       out_valid, locked, sync_err;
  logic [2:0] sel;

  int checks = 0;
  int errors = 0;

  // model state
  bit         m_locked;
  bit         m_q[$];
  logic [7:0] m_out;
  bit         m_ov, m_se;
  int         ov_count;

  tdm_demux_8ch dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .fsync(fsync),
    .out(out), .out_valid(out_valid), .sel(sel), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit f, input bit d);
    m_ov = 0;
    m_se = 0;
    if (r) begin
      m_q.delete();
      m_locked = 0;
      m_out    = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (f) begin m_q = {d}; m_locked = 1; end
      end else if (m_q.size() == 0) begin
        if (f) m_q = {d};
        else begin m_se = 1; m_locked = 0; end
      end else if (f) begin
        m_se = 1;
        m_q  = {d};
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 8) begin
          for (int k = 0; k < 8; k++) m_out[k] = m_q[k];
          m_ov = 1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input bit f, input bit d);
    rst = r; in_valid = v; fsync = f; in = d;
    @(posedge clk);
    model_edge(r, v, f, d);
    #1;
    if (m_ov) ov_count++;
    check("out", out, m_out);
    check("out_valid", out_valid, m_ov);
    check("sel", sel, m_q.size());
    check("locked", locked, m_locked);
    check("sync_err", sync_err, m_se);
  endtask

  task automatic frame(input logic [7:0] b, input int gap_after, input int gapn);
    for (int k = 0; k < 8; k++) begin
      step(0, 1, k == 0, b[k]);
      if (k == gap_after)
        for (int g = 0; g < gapn; g++) step(0, 0, $urandom_range(1), $urandom_range(1));
    end
  endtask

  task automatic partial(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) step(0, 1, k == 0, b[k]);
  endtask

  initial begin
    int vcnt;
    m_locked = 0; m_out = '0; m_ov = 0; m_se = 0; ov_count = 0;
    rst = 1; in = 0; in_valid = 0; fsync = 0;

    // reset state
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    check("rst_out", out, 8'h00);
    check("rst_locked", locked, 1'b0);
    check("rst_sel", sel, 3'd0);

    // hunt discards non-fsync samples
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    check("hunt_sel", sel, 3'd0);

    // clean frame: slots 0..7 = 1,0,1,1,0,0,1,0
    frame(8'b0100_1101, -1, 0);
    check("clean_out", out, 8'h4D);
    check("clean_ov", out_valid, 1'b1);
    check("clean_locked", locked, 1'b1);
    step(0, 0, 0, 0);
    check("ov_single", out_valid, 1'b0);

    // back-to-back frames
    ov_count = 0;
    frame(8'hA5, -1, 0); check("b2b_0", out, 8'hA5);
    frame(8'h3C, -1, 0); check("b2b_1", out, 8'h3C);
    frame(8'hFF, -1, 0); check("b2b_2", out, 8'hFF);
    check("b2b_count", ov_count, 3);

    // 3-cycle valid gap between slots 4 and 5
    frame(8'h4D, 4, 3);
    check("gap_out", out, 8'h4D);
    check("gap_ov", out_valid, 1'b1);

    // early fsync at slot 5
    frame(8'h11, -1, 0);
    partial(8'hE7, 5);
    frame(8'h96, -1, 0);
    check("early_out", out, 8'h96);

    // missing fsync at slot 0
    step(0, 1, 0, 1);
    check("miss_err", sync_err, 1'b1);
    check("miss_locked", locked, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, $urandom_range(1));
    frame(8'h5A, -1, 0);
    check("miss_out", out, 8'h5A);

    // reset mid-frame at slot 3
    partial(8'hC3, 3);
    step(1, 1, 0, 1);
    check("midrst_out", out, 8'h00);
    check("midrst_locked", locked, 1'b0);
    check("midrst_ov", out_valid, 1'b0);
    frame(8'h81, -1, 0);
    check("post_rst_out", out, 8'h81);

    // random traffic, mostly well-framed with occasional perturbation
    vcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      bit v, f, r;
      r = ($urandom_range(199) == 0);
      v = ($urandom_range(3) != 0);
      f = (vcnt % 8 == 0);
      if ($urandom_range(15) == 0) f = ~f;
      step(r, v, f, $urandom_range(1));
      if (v) vcnt++;
      if ($urandom_range(63) == 0) vcnt = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux_8ch.md
# tdm_demux_8ch

Time-division demultiplexer that receives the serial stream produced by an 8-to-1 slot multiplexer and reconstructs the 8 parallel channel bits. Frame alignment comes from a slot-0 frame-sync strobe. Each complete frame is presented as one registered 8-bit word with a single-cycle valid pulse. Sits at the receive end of the 8-channel TDM link, feeding per-channel consumers.

## Interface
- NCH, 8, number of channels/slots per frame (fixed at 8 for this block)
- SELW, 3, slot index width, log2(NCH)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in  in  1  serial data bit for the current slot
- in_valid  in  1  qualifies in/fsync; a sample is accepted only when high
- fsync  in  1  high together with in_valid marks that sample as slot 0
- out  out  NCH  last complete frame; out[k] = bit received in slot k
- out_valid  out  1  one-cycle pulse when out is updated
- sel  out  SELW  slot index the next accepted sample will occupy
- locked  out  1  high while in LOCK state
- sync_err  out  1  one-cycle pulse on a framing violation

## Operation
- States: HUNT, LOCK.
- Reset: state HUNT, shadow register 0, out 0, out_valid 0, sel 0, locked 0, sync_err 0.
- HUNT:
  - Samples without fsync are discarded and sel stays 0.
  - Sample with fsync: shadow[0] <= in, sel <= 1, go to LOCK.
- LOCK, accepted sample at slot sel:
  - sel in 1..7 with fsync low: shadow[sel] <= in, sel <= sel+1 (mod 8).
  - sel = 7 and sample accepted: out <= {in, shadow[6:0]}, out_valid pulses, sel wraps to 0.
  - sel = 0 with fsync high: normal frame start, shadow[0] <= in, sel <= 1.
  - sel = 0 with fsync low (missing sync): sync_err pulses, sample discarded, go to HUNT, sel 0.
  - sel in 1..7 with fsync high (early sync): sync_err pulses, partial frame dropped with no out_valid, sample taken as slot 0 (shadow[0] <= in, sel <= 1), stay in LOCK.
- in_valid low: no state, sel or shadow change; all pulses low.
- out holds its value between frames and is never partially updated.
- Shadow bits from a dropped frame are not cleared. They are overwritten before the next out update.

## Timing
- All outputs are registered.
- out/out_valid are updated in the cycle after the clock edge that accepts the slot-7 sample: 1-cycle latency from the last bit.
- Minimum frame time is 8 consecutive in_valid cycles, which gives out_valid at most once per 8 cycles. Back-to-back frames are sustained with no dead cycle.
- sync_err is asserted for exactly one cycle, in the cycle after the offending sample.
- locked rises the cycle after the first fsync sample in HUNT. It falls the cycle after a missing-sync sample.
- rst overrides everything, including mid-frame. The partial frame is lost, outputs return to reset values on the next edge, and no pulse is emitted.

## Structure
- Shared package tdm_pkg holds:
  - the NCH and SELW constants;
  - the state enum (HUNT, LOCK).
- These are shared with the transmit-side TDM multiplexer.
- One sub-module: tdm_slot_counter. It is a SELW-bit mod-NCH counter with synchronous clear, load-to-1 and enable, and flags wrap at 7.
- Top level contains the FSM, shadow register and output register.

## Test plan
- Reset then one clean frame with bits slot0..7 = 1,0,1,1,0,0,1,0 (fsync on slot 0) -> out = 8'b0100_1101, one out_valid pulse, locked 1, sync_err never.
- Three back-to-back frames 8'hA5, 8'h3C, 8'hFF with in_valid held high -> out_valid every 8th cycle, outs in order, no gaps.
- Frame with in_valid low for 3 cycles between slots 4 and 5 -> same out as the uninterrupted frame; out_valid is delayed by 3 cycles.
- Early fsync at slot 5 after a valid frame -> sync_err pulse, no out_valid for the partial frame. The following 8 samples form a complete frame and are output correctly.
- Missing fsync at slot 0 in LOCK -> sync_err pulse, locked drops, samples are ignored until the next fsync, then the next full frame is output correctly.
- rst asserted at slot 3 of a frame -> next cycle all outputs 0 and state HUNT. A subsequent frame starting with fsync decodes correctly.
